// File: rtl/mn_sweep_scheduler_pkg.sv
// Shared constants for the motor-neuron sweep scheduler: FSM encodings,
// sweep geometry derived from the neuron index width, and the step-period rule.
package mn_sched_pkg;

  localparam int NN_DEFAULT       = 8;
  localparam int PIPE_LAT_DEFAULT = 2;
  localparam int SUBSTEPS_LOG2    = 2;

  localparam int NUM_NEURON = 2 ** (NN_DEFAULT + 1);
  localparam int SWEEP_LEN  = NUM_NEURON * (2 ** SUBSTEPS_LOG2);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SWEEP   = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_PUBLISH = 2'd3;

  function automatic int num_neuron_of(input int nn);
    return 2 ** (nn + 1);
  endfunction

  function automatic int sweep_len_of(input int nn);
    return num_neuron_of(nn) * (2 ** SUBSTEPS_LOG2);
  endfunction

  // substep field sits directly above the neuron index
  function automatic int substep_lsb(input int nn);
    return nn + 1;
  endfunction

  function automatic int substep_msb(input int nn);
    return nn + SUBSTEPS_LOG2;
  endfunction

  // a zero half-period is treated as one so the step never stalls
  function automatic logic [32:0] step_period(input logic [31:0] half);
    return (half == 32'd0) ? 33'd2 : {half, 1'b0};
  endfunction

endpackage

// File: rtl/mn_sweep_scheduler_if.sv
// Per-step spike-count handoff from the scheduler to the muscle/EMG stage.
interface mn_sweep_scheduler_if;
  logic [31:0] cnt_data;
  logic        cnt_valid;
  logic        cnt_ready;

  modport master (output cnt_data, output cnt_valid, input cnt_ready);
  modport slave  (input cnt_data, input cnt_valid, output cnt_ready);
endinterface

// File: rtl/mn_sweep_scheduler_step_timer.sv
// Free-running step-period counter; emits a registered one-cycle sim_tick when
// the counter reaches P-1 and re-samples half_cnt only on the wrap.
module mn_step_timer
  import mn_sched_pkg::*;
(
  input  logic        rawclk,
  input  logic        reset_sim_n,
  input  logic [31:0] half_cnt,
  output logic        sim_tick
);

  logic [32:0] count_r;
  logic [32:0] period_r;
  logic        loaded_r;
  logic [32:0] period_cur_s;
  logic [32:0] period_nxt_s;
  logic [32:0] count_nxt_s;
  logic        wrap_s;

  // The first cycle after reset behaves like a wrap: the live half_cnt sets P.
  always_comb begin
    period_cur_s = period_r;
    period_nxt_s = period_r;
    count_nxt_s  = count_r + 33'd1;
    if (loaded_r) begin
      period_cur_s = period_r;
    end else begin
      period_cur_s = step_period(half_cnt);
    end
    wrap_s = (count_r == (period_cur_s - 33'd1));
    if (wrap_s) begin
      count_nxt_s = 33'd0;
    end else begin
      count_nxt_s = count_r + 33'd1;
    end
    if (wrap_s || !loaded_r) begin
      period_nxt_s = step_period(half_cnt);
    end else begin
      period_nxt_s = period_r;
    end
  end

  // Counter, period latch and the registered tick.
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      count_r  <= 33'd0;
      period_r <= 33'd0;
      loaded_r <= 1'b0;
      sim_tick <= 1'b0;
    end else begin
      count_r  <= count_nxt_s;
      period_r <= period_nxt_s;
      loaded_r <= 1'b1;
      sim_tick <= (count_nxt_s == (period_nxt_s - 33'd1));
    end
  end

endmodule

// File: rtl/mn_sweep_scheduler.sv
// Per-step sweep of the time-multiplexed neuron counter, pipeline-aligned spike
// counting, and valid/ready publication of the count with sticky timing flags.
module mn_sweep_scheduler
  import mn_sched_pkg::*;
#(
  parameter int NN       = NN_DEFAULT,
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
  input  logic                 rawclk,
  input  logic                 reset_sim_n,
  input  logic                 enable,
  input  logic [31:0]          half_cnt,
  input  logic                 pool_spike,
  output logic [NN+2:0]        neuron_counter,
  output logic                 slot_valid,
  output logic                 sim_tick,
  mn_sweep_scheduler_if.master cnt,
  output logic                 late_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int              SLOT_W     = substep_msb(NN) + 1;
  localparam logic [NN+2:0]   SLOT_LAST  = SLOT_W'(sweep_len_of(NN) - 1);
  localparam int              DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [DRAIN_W-1:0]  drain_cnt_r;
  logic [PIPE_LAT-1:0] qual_dly_r;
  logic                qual_s;
  logic [31:0]         acc_r;
  logic [31:0]         cnt_data_r;
  logic                cnt_valid_r;

  mn_step_timer u_step_timer (
    .rawclk      (rawclk),
    .reset_sim_n (reset_sim_n),
    .half_cnt    (half_cnt),
    .sim_tick    (sim_tick)
  );

  assign qual_s        = qual_dly_r[PIPE_LAT-1];
  assign cnt.cnt_data  = cnt_data_r;
  assign cnt.cnt_valid = cnt_valid_r;

  // Next-state: a tick only launches a sweep from IDLE; enable is not consulted later.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sim_tick && enable) state_nxt_s = ST_SWEEP;
        else                    state_nxt_s = ST_IDLE;
      end
      ST_SWEEP: begin
        if (neuron_counter == SLOT_LAST) state_nxt_s = ST_DRAIN;
        else                             state_nxt_s = ST_SWEEP;
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) state_nxt_s = ST_PUBLISH;
        else                           state_nxt_s = ST_DRAIN;
      end
      ST_PUBLISH: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, slot counter and drain timer.
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      state_r        <= ST_IDLE;
      busy           <= 1'b0;
      neuron_counter <= '0;
      slot_valid     <= 1'b0;
      drain_cnt_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (state_nxt_s == ST_SWEEP) begin
            neuron_counter <= '0;
            slot_valid     <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (neuron_counter == SLOT_LAST) begin
            slot_valid  <= 1'b0;
            drain_cnt_r <= '0;
          end else begin
            neuron_counter <= neuron_counter + SLOT_W'(1);
          end
        end
        ST_DRAIN: drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
        default: ;
      endcase
    end
  end

  // slot_valid delayed to line up with the pool's spike sample for that slot.
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      qual_dly_r <= '0;
    end else begin
      qual_dly_r[0] <= slot_valid;
      for (int i = 1; i < PIPE_LAT; i++) begin
        qual_dly_r[i] <= qual_dly_r[i-1];
      end
    end
  end

  // Saturating spike accumulator, cleared as its value is published.
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      acc_r <= 32'd0;
    end else if (state_r == ST_PUBLISH) begin
      acc_r <= 32'd0;
    end else if (qual_s && pool_spike && (acc_r != 32'hFFFF_FFFF)) begin
      acc_r <= acc_r + 32'd1;
    end
  end

  // Publish has priority over acceptance; an unconsumed count is overwritten.
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      cnt_data_r  <= 32'd0;
      cnt_valid_r <= 1'b0;
      overrun_err <= 1'b0;
      late_err    <= 1'b0;
    end else begin
      if (state_r == ST_PUBLISH) begin
        cnt_data_r  <= acc_r;
        cnt_valid_r <= 1'b1;
        if (cnt_valid_r && !cnt.cnt_ready) overrun_err <= 1'b1;
      end else if (cnt_valid_r && cnt.cnt_ready) begin
        cnt_valid_r <= 1'b0;
      end
      if (sim_tick && (state_r != ST_IDLE)) late_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mn_sweep_scheduler.sv
// Randomized scoreboard bench for mn_sweep_scheduler at NN=1, PIPE_LAT=2:
// a cycle-scheduled reference model predicts ticks, sweeps and counts.
module tb_mn_sweep_scheduler;

  localparam int NN       = 1;
  localparam int PIPE_LAT = 2;
  localparam int SWEEP    = 16;
  localparam int BUSY_LEN = SWEEP + PIPE_LAT + 1;

  logic          rawclk = 1'b0;
  logic          reset_sim_n = 1'b1;
  logic          enable;
  logic [31:0]   half_cnt;
  logic          pool_spike;
  logic [NN+2:0] neuron_counter;
  logic          slot_valid, sim_tick, late_err, overrun_err, busy;

  mn_sweep_scheduler_if cnt_bus();

  mn_sweep_scheduler #(.NN(NN), .PIPE_LAT(PIPE_LAT)) dut (
    .rawclk         (rawclk),
    .reset_sim_n    (reset_sim_n),
    .enable         (enable),
    .half_cnt       (half_cnt),
    .pool_spike     (pool_spike),
    .neuron_counter (neuron_counter),
    .slot_valid     (slot_valid),
    .sim_tick       (sim_tick),
    .cnt            (cnt_bus),
    .late_err       (late_err),
    .overrun_err    (overrun_err),
    .busy           (busy)
  );

  always #5 rawclk = ~rawclk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // reference model state
  int          next_tick;
  int          sweep_t = -1000;
  int unsigned acc;
  bit          m_valid, m_late, m_over;
  int unsigned exp_q[$];
  bit          chk_en = 1'b0;

  // expected outputs of the current cycle
  bit          e_tick, e_busy, e_slot, e_valid, e_late, e_over;
  int          e_nc;
  int unsigned e_data;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int period_of(input int unsigned h);
    return (h == 0) ? 2 : 2 * int'(h);
  endfunction

  task automatic model_reset();
    sweep_t   = -1000;
    acc       = 0;
    m_valid   = 1'b0;
    m_late    = 1'b0;
    m_over    = 1'b0;
    exp_q.delete();
    next_tick = cyc + period_of(half_cnt) - 1;
  endtask

  task automatic model_cycle();
    int c;
    c       = cyc;
    e_tick  = (c == next_tick);
    e_busy  = (c >= sweep_t + 1) && (c <= sweep_t + BUSY_LEN);
    e_slot  = (c >= sweep_t + 1) && (c <= sweep_t + SWEEP);
    e_nc    = c - sweep_t - 1;
    e_valid = m_valid;
    e_late  = m_late;
    e_over  = m_over;
    e_data  = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : 0;
    chk_en  = 1'b1;
    if (pool_spike && (c >= sweep_t + 1 + PIPE_LAT) && (c <= sweep_t + SWEEP + PIPE_LAT)) acc++;
    if (c == sweep_t + BUSY_LEN) begin
      if (m_valid && !cnt_bus.cnt_ready) begin
        m_over = 1'b1;
        void'(exp_q.pop_back());
      end
      m_valid = 1'b1;
      exp_q.push_back(acc);
    end else if (m_valid && cnt_bus.cnt_ready) begin
      m_valid = 1'b0;
    end
    if (c == next_tick) begin
      next_tick = c + period_of(half_cnt);
      if (c <= sweep_t + BUSY_LEN) m_late = 1'b1;
      else if (enable) begin
        sweep_t = c;
        acc     = 0;
      end
    end
  endtask

  task automatic step(input bit en, input bit spk, input bit rdy, input int unsigned h);
    @(posedge rawclk);
    #1;
    cyc++;
    enable            = en;
    pool_spike        = spk;
    cnt_bus.cnt_ready = rdy;
    half_cnt          = h;
    if (reset_sim_n) model_cycle();
  endtask

  task automatic apply_reset(input int unsigned h);
    reset_sim_n = 1'b0;
    chk_en      = 1'b0;
    #1;
    check("reset_outputs", {neuron_counter, slot_valid, sim_tick, cnt_bus.cnt_data,
                            cnt_bus.cnt_valid, late_err, overrun_err, busy}, 0);
    repeat (3) step(1'b0, 1'b1, 1'b1, h);
    #1;
    reset_sim_n = 1'b1;
    model_reset();
  endtask

  // monitor: per-cycle status and scoreboard pop on every accepted count
  initial begin
    forever begin
      @(negedge rawclk);
      if (chk_en && reset_sim_n) begin
        check("sim_tick", sim_tick, e_tick);
        check("busy", busy, e_busy);
        check("slot_valid", slot_valid, e_slot);
        check("late_err", late_err, e_late);
        check("overrun_err", overrun_err, e_over);
        check("cnt_valid", cnt_bus.cnt_valid, e_valid);
        if (e_slot) check("neuron_counter", neuron_counter, e_nc);
        if (e_valid) check("cnt_data_held", cnt_bus.cnt_data, e_data);
        if (cnt_bus.cnt_valid && cnt_bus.cnt_ready) begin
          check("cnt_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("cnt_data_accept", cnt_bus.cnt_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int guard;
    enable            = 1'b0;
    pool_spike        = 1'b0;
    cnt_bus.cnt_ready = 1'b1;
    half_cnt          = 32'd16;
    #2;
    apply_reset(32'd16);
    // basic steps with sparse random spikes
    repeat (200) step(1'b1, ($urandom_range(0, 3) == 0), 1'b1, 32'd16);
    // pool_spike held high: only qualified slots count
    repeat (100) step(1'b1, 1'b1, 1'b1, 32'd16);
    // backpressure across two publishes, then random ready
    repeat (70)  step(1'b1, ($urandom_range(0, 1) == 1), 1'b0, 32'd16);
    repeat (300) step(1'b1, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 32'd16);
    // step period shorter than the busy window
    repeat (150) step(1'b1, ($urandom_range(0, 1) == 1), 1'b1, 32'd8);
    // reset in the middle of a sweep
    apply_reset(32'd16);
    guard = 0;
    while (!(e_slot && e_nc == 7) && guard < 200) begin
      step(1'b1, 1'b1, 1'b1, 32'd16);
      guard++;
    end
    check("reach_slot7", (e_slot && e_nc == 7), 1);
    apply_reset(32'd16);
    repeat (120) step(1'b1, ($urandom_range(0, 1) == 1), 1'b1, 32'd16);
    // enable dropped mid-sweep: that sweep still publishes
    guard = 0;
    while (!(e_slot && e_nc == 5) && guard < 200) begin
      step(1'b1, ($urandom_range(0, 1) == 1), 1'b1, 32'd16);
      guard++;
    end
    check("reach_slot5", (e_slot && e_nc == 5), 1);
    repeat (100) step(1'b0, ($urandom_range(0, 1) == 1), 1'b1, 32'd16);
    // half_cnt = 0 gives the minimum period
    repeat (80) step(1'b1, ($urandom_range(0, 1) == 1), 1'b1, 32'd0);
    check("late_after_min_period", late_err, 1);
    // random mix of enable, ready and half period
    apply_reset(32'd12);
    repeat (600) step(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 2) != 0), $urandom_range(0, 24));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
